// File: rtl/pipe_reg_id_ie_skid.sv
// rtl/pipe_reg_id_ie_skid.sv - decode-to-execute pipeline register with 2-entry skid buffer
module pipe_reg_id_ie_skid #(
    parameter int DATA_W = 45,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    // State encoding doubles as {skid_v, main_v}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              main_v;
    logic              skid_v;
    logic              accept;

    assign main_v    = (state == ONE) || (state == FULL);
    assign skid_v    = (state == FULL);
    assign in_ready  = !skid_v;
    assign accept    = in_valid && in_ready;
    assign out_valid = main_v;
    assign out_data  = main_data;
    // Side-effecting control bits must never leak out of a bubble.
    assign out_ctrl  = main_v ? main_ctrl : '0;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            main_data <= in_data;
                            main_ctrl <= in_ctrl;
                            state     <= ONE;
                        end
                    end
                    ONE: begin
                        if (accept && out_ready) begin
                            main_data <= in_data;
                            main_ctrl <= in_ctrl;
                        end else if (accept) begin
                            skid_data <= in_data;
                            skid_ctrl <= in_ctrl;
                            state     <= FULL;
                        end else if (out_ready) begin
                            state <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (out_ready) begin
                            main_data <= skid_data;
                            main_ctrl <= skid_ctrl;
                            state     <= ONE;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end

            // Counts independently of flush; only reset clears it.
            if (main_v && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_reg_id_ie_skid.sv
// tb/tb_pipe_reg_id_ie_skid.sv - directed self-checking bench for pipe_reg_id_ie_skid
module tb_pipe_reg_id_ie_skid;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        in_valid;
    logic        in_ready;
    logic [44:0] in_data;
    logic [3:0]  in_ctrl;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [44:0] out_data;
    logic [3:0]  out_ctrl;
    logic [15:0] stall_cnt;

    logic        in_ready3;
    logic        out_valid3;
    logic [44:0] out_data3;
    logic [3:0]  out_ctrl3;
    logic [2:0]  stall_cnt3;

    int vectors = 0;
    int miscompares = 0;

    pipe_reg_id_ie_skid dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    pipe_reg_id_ie_skid #(.CNT_W(3)) dut3 (
        .clk_in(clk_in), .rst_in(rst_in),
        .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3), .out_ctrl(out_ctrl3),
        .stall_cnt(stall_cnt3)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst_in    = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall_cnt", stall_cnt, 0);
        step();
        step();
        rst_in = 1'b0;

        // Streaming
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 4'b1001;
        in_data   = 45'h1;
        step();
        chk("stream1_valid", out_valid, 1);
        chk("stream1_data", out_data, 45'h1);
        chk("stream1_ctrl", out_ctrl, 4'b1001);
        chk("stream1_in_ready", in_ready, 1);
        in_data = 45'h2;
        step();
        chk("stream2_data", out_data, 45'h2);
        chk("stream2_in_ready", in_ready, 1);
        in_data = 45'h3;
        step();
        chk("stream3_data", out_data, 45'h3);
        chk("stream3_ctrl", out_ctrl, 4'b1001);
        in_valid = 1'b0;
        step();
        chk("drain_valid", out_valid, 0);

        // Bubble gating
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bubble_valid", out_valid, 0);
            chk("bubble_ctrl", out_ctrl, 0);
        end

        // Skid fill plus stall counter
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'b0011;
        in_data   = 45'hA;
        step();
        chk("skidA_data", out_data, 45'hA);
        chk("skidA_in_ready", in_ready, 1);
        chk("skidA_stall", stall_cnt, 0);
        in_data = 45'hB;
        step();
        chk("full_in_ready", in_ready, 0);
        chk("full_out_data", out_data, 45'hA);
        chk("full_out_valid", out_valid, 1);
        chk("full_stall", stall_cnt, 1);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("stall_5", stall_cnt, 5);
        chk("stall3_5", stall_cnt3, 5);
        for (int i = 0; i < 5; i++) step();
        chk("stall_10", stall_cnt, 10);
        chk("stall3_sat", stall_cnt3, 7);
        chk("held_out_data", out_data, 45'hA);

        out_ready = 1'b1;
        #1;
        chk("pop_head_A", out_data, 45'hA);
        chk("pop_in_ready_still0", in_ready, 0);
        step();
        chk("pop_head_B", out_data, 45'hB);
        chk("pop_ctrl_B", out_ctrl, 4'b0011);
        chk("pop_in_ready_back", in_ready, 1);
        chk("pop_stall_hold", stall_cnt, 10);
        step();
        chk("pop_empty", out_valid, 0);

        // Flush collision while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 4'b1111;
        in_data   = 45'h11;
        step();
        in_data = 45'h12;
        step();
        chk("fl_full", in_ready, 0);
        chk("fl_stall", stall_cnt, 11);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = 45'h13;
        step();
        chk("fl_out_valid", out_valid, 0);
        chk("fl_out_ctrl", out_ctrl, 0);
        chk("fl_in_ready", in_ready, 1);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        chk("fl_no_ghost", out_valid, 0);
        chk("fl_stall_kept", stall_cnt, 11);
        chk("fl_stall3_kept", stall_cnt3, 7);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 45'h21;
        step();
        in_data = 45'h22;
        step();
        chk("ar_full", in_ready, 0);
        chk("ar_stall", stall_cnt, 12);
        #3;
        rst_in = 1'b1;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_in_ready", in_ready, 1);
        chk("ar_stall_clr", stall_cnt, 0);
        chk("ar_stall3_clr", stall_cnt3, 0);
        chk("ar_out_data", out_data, 0);
        chk("ar_out_ctrl", out_ctrl, 0);
        in_valid = 1'b0;
        step();
        rst_in = 1'b0;
        step();
        chk("ar_after_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
